fp_input_arbiter: RTL
=====================

// Module: fp_input_arbiter
// PURPOSE
//  Two-input packet arbiter in front of the FP stage. Merges two 62-bit packet streams
//  (matching-stage output and external/re-injected packets) onto the single FP_Stage
//  input, using the same Send/Ack four-phase handshake.
//  Registers the winning packet, holds it stable for FP_Stage, applies round-robin fairness.
// PARAMETERS
//  PKT_W   62   packet width {color,gen,dest,LR2,BR,CPY,OPC,C,Z,DataL,DataR}
// PORTS
//  CP          in   1      clock; single clock domain, rising edge
//  MR          in   1      master reset, asynchronous, active-high
//  PACKET_IN0  in   PKT_W  packet from source 0
//  Send_in0    in   1      source 0 request (four-phase)
//  Ack_out0    out  1      acknowledge to source 0
//  PACKET_IN1  in   PKT_W  packet from source 1
//  Send_in1    in   1      source 1 request (four-phase)
//  Ack_out1    out  1      acknowledge to source 1
//  HOLD        in   1      1 = start no new grant (in-flight transfer completes)
//  PACKET_OUT  out  PKT_W  registered packet to FP_Stage PACKET_IN
//  Send_out    out  1      request to FP_Stage Send_in
//  Ack_in      in   1      acknowledge from FP_Stage Ack_out
//  GRANT       out  1      index of last captured source
//  BUSY        out  1      1 while state != IDLE
// BEHAVIOUR
//  Reset (MR=1, async, any state, incl. mid-transfer):
//  - state=IDLE; PACKET_OUT=0, Send_out=0, Ack_out0=Ack_out1=0, GRANT=0, BUSY=0.
//  - Internal last-grant pointer LG=1, so source 0 wins first contention.
//  Eligibility: elig[i] = Send_in[i] & ~Ack_out[i]. A source is not regranted until it
//  has returned to zero.
//  FSM (one transition per CP edge):
//  - IDLE: if HOLD=0 and elig!=0: pick winner w.
//    - Only one eligible: that one. Both eligible: w = ~LG.
//    - Edge: PACKET_OUT<=PACKET_IN[w], Ack_out[w]<=1, Send_out<=1, GRANT<=w, LG<=w -> XFER.
//    - HOLD=1 or elig==0: stay; outputs unchanged.
//  - XFER: Send_out=1; on edge with Ack_in=1: Send_out<=0 -> RTZ; else stay.
//  - RTZ: on edge with Ack_in=0 -> IDLE; else stay.
//  Input-side release (independent of FSM state):
//  - On an edge where Ack_out[i]=1 and Send_in[i]=0: Ack_out[i]<=0.
//  - Capture and release never target the same i on one edge (elig excludes Ack_out=1).
//  Latency: Send_in rise (sampled in IDLE) -> Send_out=1 one edge later.
//  - Minimum 3 edges per packet (IDLE->XFER->RTZ->IDLE).
//  PACKET_OUT: stable from capture until the next capture.
//  - Sources may change PACKET_IN once Ack_out is high.
//  Ack_in=1 while IDLE: ignored. Send_in toggling while XFER/RTZ: only affects release/elig.
//  HOLD: checked only in IDLE; asserting it during XFER/RTZ does not abort the transfer.
//  Simultaneous: release of source a and capture of source b on the same edge is legal.
//  No packet is dropped or duplicated; each accepted Send_in produces exactly one Send_out.
// CONFIGURATION
//  FP_ARB_FIXED_PRIO_EN defined:
//  - Both eligible -> source 0 always wins; LG still updated but unused.
//  - Source 1 may starve.
//  Undefined (default): round-robin as above.
// TESTING
//  1 MR=1 mid-XFER -> next cycle all outputs 0, BUSY=0; after MR=0, source 0 wins first contention.
//  2 Src0 only, PACKET_IN0=62'h0ABC_1234_5678_9AB:
//    - edge1: Send_out=1, Ack_out0=1, PACKET_OUT=that value, GRANT=0.
//    - Ack_in=1 -> Send_out=0; Ack_in=0 -> IDLE.
//  3 Both Send_in high continuously, sources RTZ promptly -> GRANT 0,1,0,1 over 4 packets;
//    with FP_ARB_FIXED_PRIO_EN -> 0,0,0,0.
//  4 HOLD=1 in IDLE with Send_in1=1 -> Send_out stays 0, Ack_out1=0.
//    - HOLD->0 -> capture next edge.
//  5 Src0 keeps Send_in0=1 after its ack -> not regranted; src1 request granted meanwhile.
//    - Src0 drop -> Ack_out0=0, then src0 re-eligible.
//  6 Random Send/Ack delays 0-5 cycles, 1000 packets -> scoreboard: output order = grant order,
//    no loss/duplication, PACKET_OUT stable while Send_out=1.

Source files
------------

// File: rtl/fp_input_arbiter.sv
// Two-source four-phase packet arbiter feeding the FP stage; registers and holds the winning packet.
// Optional build macro FP_ARB_FIXED_PRIO_EN: source 0 always wins contention (default round-robin).
module fp_input_arbiter #(
  parameter int PKT_W = 62
) (
  input  logic             CP,
  input  logic             MR,
  input  logic [PKT_W-1:0] PACKET_IN0,
  input  logic             Send_in0,
  output logic             Ack_out0,
  input  logic [PKT_W-1:0] PACKET_IN1,
  input  logic             Send_in1,
  output logic             Ack_out1,
  input  logic             HOLD,
  output logic [PKT_W-1:0] PACKET_OUT,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic             GRANT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t state;
  logic   lg;
  logic   elig0;
  logic   elig1;
  logic   win;

  // A source whose ack is still high has not returned to zero and cannot be regranted.
  always_comb begin
    elig0 = Send_in0 & ~Ack_out0;
    elig1 = Send_in1 & ~Ack_out1;
    if (elig0 && elig1) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~lg;
`endif
    end else begin
      win = elig1;
    end
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state      <= IDLE;
      lg         <= 1'b1;
      PACKET_OUT <= '0;
      Send_out   <= 1'b0;
      Ack_out0   <= 1'b0;
      Ack_out1   <= 1'b0;
      GRANT      <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      // Input-side release runs regardless of state; capture never targets an acked source.
      if (Ack_out0 && !Send_in0) Ack_out0 <= 1'b0;
      if (Ack_out1 && !Send_in1) Ack_out1 <= 1'b0;

      case (state)
        IDLE: begin
          if (!HOLD && (elig0 || elig1)) begin
            PACKET_OUT <= win ? PACKET_IN1 : PACKET_IN0;
            if (win) Ack_out1 <= 1'b1;
            else     Ack_out0 <= 1'b1;
            Send_out <= 1'b1;
            GRANT    <= win;
            lg       <= win;
            BUSY     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (Ack_in) begin
            Send_out <= 1'b0;
            state    <= RTZ;
          end
        end
        RTZ: begin
          if (!Ack_in) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
